// File: rtl/core_sched_pkg.sv
// Shared defaults, state encoding and width helper for the core start scheduler.
package core_sched_pkg;

  localparam int unsigned DEF_N_CORES      = 4;
  localparam int unsigned DEF_N_CTX        = 2;
  localparam int unsigned DEF_N_SEQ        = 2;
  localparam int unsigned DEF_STAGGER      = 4;
  localparam int unsigned DEF_FRAME_CYCLES = 72;

  localparam logic [15:0] SKIP_MAX = '1;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } sched_state_t;

  // Width needed to index n items; never narrower than one bit.
  function automatic int unsigned w_of(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/core_sched_seq_mem.sv
// Per-core/per-context sequence counters: indexed read, increment at the same index.
module sched_seq_mem #(
  parameter int unsigned IDX_W = 3,
  parameter int unsigned SEQ_W = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic             inc,
  output logic [SEQ_W-1:0] rd_seq
);

  localparam int unsigned DEPTH = 2 ** IDX_W;

  logic [SEQ_W-1:0] mem [DEPTH];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (inc) begin
      mem[rd_idx] <= mem[rd_idx] + SEQ_W'(1);
    end
  end

  assign rd_seq = mem[rd_idx];

endmodule

// File: rtl/core_sched.sv
// Staggered start scheduler: one slot per core per frame, contexts rotate per frame,
// starts issued only to ready contexts, skipped slots counted with saturation.
module core_sched
  import core_sched_pkg::*;
#(
  parameter int unsigned N_CORES      = DEF_N_CORES,
  parameter int unsigned N_CTX        = DEF_N_CTX,
  parameter int unsigned N_SEQ        = DEF_N_SEQ,
  parameter int unsigned STAGGER      = DEF_STAGGER,
  parameter int unsigned FRAME_CYCLES = DEF_FRAME_CYCLES,
  localparam int unsigned CTX_W       = $clog2(N_CTX),
  localparam int unsigned SEQ_W       = $clog2(N_SEQ)
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       en,
  input  logic [N_CORES*N_CTX-1:0]   core_ready,
  input  logic                       stat_clr,
  output logic [N_CORES-1:0]         core_start,
  output logic [CTX_W-1:0]           start_ctx,
  output logic [SEQ_W-1:0]           start_seq,
  output logic                       idle,
  output logic [15:0]                skip_cnt
);

  localparam int unsigned CORE_W = w_of(N_CORES);
  localparam int unsigned CNT_W  = w_of(FRAME_CYCLES);
  localparam int unsigned IDX_W  = CORE_W + CTX_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

  sched_state_t      state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [CTX_W-1:0]  ctx, ctx_nx;
  logic              active, slot_hit, fire, skip;
  logic [CORE_W-1:0] slot_core;
  logic [IDX_W-1:0]  slot_idx;
  logic [SEQ_W-1:0]  seq_rd;
  logic [N_CORES-1:0] start_vec;

  // IDLE with en=1 already evaluates the cnt=0 slot, so no start-up gap cycle.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    ctx_nx    = ctx;
    active    = (state == ST_RUN) || en;
    slot_hit  = 1'b0;
    slot_core = '0;
    for (int unsigned i = 0; i < N_CORES; i++) begin
      if (cnt == CNT_W'(i * STAGGER)) begin
        slot_hit  = active;
        slot_core = CORE_W'(i);
      end
    end
    slot_idx  = {slot_core, ctx};
    fire      = slot_hit && core_ready[slot_idx];
    skip      = slot_hit && !core_ready[slot_idx];
    start_vec = fire ? (N_CORES'(1) << slot_core) : '0;
    if (active) begin
      if (cnt == CNT_LAST) begin
        cnt_nx   = '0;
        ctx_nx   = ctx + CTX_W'(1);
        state_nx = en ? ST_RUN : ST_IDLE;
      end else begin
        cnt_nx   = cnt + CNT_W'(1);
        state_nx = ST_RUN;
      end
    end
  end

  sched_seq_mem #(
    .IDX_W (IDX_W),
    .SEQ_W (SEQ_W)
  ) u_seq_mem (
    .CLK    (CLK),
    .RST    (RST),
    .rd_idx (slot_idx),
    .inc    (fire),
    .rd_seq (seq_rd)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      ctx        <= '0;
      core_start <= '0;
      start_ctx  <= '0;
      start_seq  <= '0;
      idle       <= 1'b1;
      skip_cnt   <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      ctx        <= ctx_nx;
      core_start <= start_vec;
      idle       <= (state_nx == ST_IDLE);
      if (fire) begin
        start_ctx <= ctx;
        start_seq <= seq_rd;
      end
      if (stat_clr)
        skip_cnt <= '0;
      else if (skip && skip_cnt != SKIP_MAX)
        skip_cnt <= skip_cnt + 16'd1;
    end
  end

endmodule
